// File: rtl/l1_fetch_cache.sv
// Direct-mapped L1 fetch cache, one backend line read per miss.
// Blocking: one outstanding fill at a time; flush drops every valid bit.
module l1_fetch_cache #(
  parameter int ARCH_SIZE  = 32,
  parameter int CACHE_SIZE = 64,
  parameter int LINES      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic [ARCH_SIZE-1:0]  cpu_addr,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_done,
  output logic                  busy,
  input  logic                  flush,
  output logic                  mem_read,
  output logic [ARCH_SIZE-1:0]  mem_address,
  input  logic [CACHE_SIZE-1:0] mem_data,
  input  logic                  mem_done,
  output logic [15:0]           miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int LA_W  = ARCH_SIZE - 3;
  localparam int TAG_W = LA_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [CACHE_SIZE-1:0] data_q [LINES];

  logic [LA_W-1:0] line_q;
  logic            sel_q;
  logic            flushed_q, flushed_d;
  logic [31:0]     fill_word_q;
  logic            cpu_done_q;
  logic [31:0]     cpu_rdata_q;
  logic [15:0]     miss_q;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] fill_tag;
  logic             lookup;
  logic             hit;
  logic             miss;
  logic             fill;
  logic [31:0]      hit_word;
  logic             unused_addr;

  assign req_idx  = cpu_addr[3 +: IDX_W];
  assign req_tag  = cpu_addr[ARCH_SIZE-1 -: TAG_W];
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[LA_W-1 -: TAG_W];

  // Byte offset within the word is irrelevant to a fetch.
  assign unused_addr = ^cpu_addr[1:0];

  assign hit_word = data_q[req_idx][{cpu_addr[2], 5'b0} +: 32];

  assign lookup = (state_q == IDLE) && cpu_req;

  // A flush in the lookup cycle forces a miss.
  assign hit = lookup && !flush
            && valid_q[req_idx]
            && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d = state_q;
    miss    = 1'b0;
    fill    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lookup && !hit) begin
          miss    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_done) begin
          fill    = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush seen while the fill is in flight keeps that line invalid.
  always_comb begin
    flushed_d = miss ? 1'b0 : (flushed_q | flush);
    valid_d   = valid_q;
    if (fill && !flushed_q && !flush) begin
      valid_d[fill_idx] = 1'b1;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      flushed_q   <= 1'b0;
      line_q      <= '0;
      sel_q       <= 1'b0;
      fill_word_q <= '0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      miss_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      flushed_q  <= flushed_d;
      cpu_done_q <= hit || (state_q == RESPOND);
      if (miss) begin
        line_q <= cpu_addr[ARCH_SIZE-1:3];
        sel_q  <= cpu_addr[2];
        miss_q <= miss_q + 16'd1;
      end
      if (fill) begin
        fill_word_q <= mem_data[{sel_q, 5'b0} +: 32];
      end
      if (hit) begin
        cpu_rdata_q <= hit_word;
      end else if (state_q == RESPOND) begin
        cpu_rdata_q <= fill_word_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data;
    end
  end

  assign busy        = (state_q != IDLE);
  assign mem_read    = (state_q == ISSUE);
  assign mem_address = {line_q, 3'b000};
  assign cpu_done    = cpu_done_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign miss_count  = miss_q;

endmodule

// File: tb/tb_l1_fetch_cache.sv
// Bench for l1_fetch_cache: transaction-level cache model, per-cycle
// output comparison, directed scenarios followed by random traffic.
module tb_l1_fetch_cache;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        busy;
  logic        flush;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [63:0] mem_data;
  logic        mem_done;
  logic [15:0] miss_count;

  l1_fetch_cache dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .busy       (busy),
    .flush      (flush),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_done   (mem_done),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  // model of cache contents
  bit          mv [16];
  logic [24:0] mt [16];
  logic [63:0] md [16];
  bit          pend;
  bit          pend_fl;

  // expected outputs for the current cycle
  bit          chk_en;
  logic        exp_done;
  logic [31:0] exp_rdata;
  logic        exp_busy;
  logic        exp_mem_read;
  logic        exp_achk;
  logic [31:0] exp_maddr;
  logic [15:0] exp_miss;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } pin_t;
  pin_t pin_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clock) begin
    pin_t p;
    if (chk_en) begin
      cmp("cpu_done", 32'(cpu_done), 32'(exp_done));
      cmp("busy", 32'(busy), 32'(exp_busy));
      cmp("mem_read", 32'(mem_read), 32'(exp_mem_read));
      cmp("miss_count", 32'(miss_count), 32'(exp_miss));
      if (exp_done) cmp("cpu_rdata", cpu_rdata, exp_rdata);
      if (exp_achk) cmp("mem_address", mem_address, exp_maddr);
    end
    while (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      cmp(p.name, p.act, p.exp);
    end
  end

  function automatic logic [31:0] word(input logic [63:0] d,
                                       input logic s);
    return s ? d[63:32] : d[31:0];
  endfunction

  task automatic pin(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    pin_t p;
    p.name = n;
    p.act  = a;
    p.exp  = e;
    pin_q.push_back(p);
  endtask

  // One clock: a flush sampled at the edge invalidates every line.
  task automatic tick();
    bit f;
    f = flush;
    @(posedge clock);
    #1;
    if (f) begin
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
      if (pend) pend_fl = 1'b1;
    end
    exp_done     = 1'b0;
    exp_busy     = 1'b0;
    exp_mem_read = 1'b0;
    exp_achk     = 1'b0;
    cpu_req      = 1'b0;
    flush        = 1'b0;
    mem_done     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] d,
                    input bit fl0, input int fl_at, input bit stray,
                    input bit md_iss, output logic [31:0] got);
    int          idx;
    int          lat;
    logic [24:0] tg;
    bit          hit;
    idx = int'(a[6:3]);
    tg  = a[31:7];
    hit = !fl0 && mv[idx] && (mt[idx] == tg);
    cpu_req  = 1'b1;
    cpu_addr = a;
    flush    = fl0;
    tick();
    if (hit) begin
      exp_done  = 1'b1;
      exp_rdata = word(md[idx], a[2]);
      got       = cpu_rdata;
    end else begin
      pend         = 1'b1;
      pend_fl      = 1'b0;
      exp_miss     = exp_miss + 16'd1;
      exp_busy     = 1'b1;
      exp_mem_read = 1'b1;
      exp_achk     = 1'b1;
      exp_maddr    = {a[31:3], 3'b000};
      lat = 200 + int'($urandom_range(0, 8));
      mem_done = md_iss;
      mem_data = {$urandom, $urandom};
      flush    = (fl_at == 0);
      if (stray) begin
        cpu_req  = 1'b1;
        cpu_addr = $urandom;
      end
      for (int w = 1; w <= lat; w++) begin
        tick();
        exp_busy = 1'b1;
        exp_achk = 1'b1;
        if (w == lat) begin
          mem_done = 1'b1;
          mem_data = d;
        end
        if (fl_at == w) flush = 1'b1;
        if (stray && w == 3) begin
          cpu_req  = 1'b1;
          cpu_addr = $urandom;
        end
      end
      tick();
      if (!pend_fl) begin
        mv[idx] = 1'b1;
        mt[idx] = tg;
        md[idx] = d;
      end
      pend     = 1'b0;
      exp_busy = 1'b1;
      tick();
      exp_done  = 1'b1;
      exp_rdata = word(d, a[2]);
      got       = cpu_rdata;
    end
  endtask

  task automatic idle(input bit fl, input bit mdn);
    flush    = fl;
    mem_done = mdn;
    mem_data = {$urandom, $urandom};
    tick();
  endtask

  // Miss, then pull reset partway through the backend wait.
  task automatic rd_reset(input logic [31:0] a);
    cpu_req  = 1'b1;
    cpu_addr = a;
    flush    = 1'b1;
    tick();
    pend         = 1'b1;
    pend_fl      = 1'b0;
    exp_miss     = exp_miss + 16'd1;
    exp_busy     = 1'b1;
    exp_mem_read = 1'b1;
    exp_achk     = 1'b1;
    exp_maddr    = {a[31:3], 3'b000};
    repeat (50) begin
      tick();
      exp_busy = 1'b1;
      exp_achk = 1'b1;
    end
    reset_n   = 1'b0;
    exp_busy  = 1'b0;
    exp_miss  = '0;
    exp_maddr = '0;
    pend      = 1'b0;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    tick();
    exp_achk = 1'b1;
    reset_n  = 1'b1;
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] g;
    logic [31:0] a;
    int          fa;
    reset_n      = 1'b0;
    cpu_req      = 1'b0;
    cpu_addr     = '0;
    flush        = 1'b0;
    mem_data     = '0;
    mem_done     = 1'b0;
    exp_done     = 1'b0;
    exp_rdata    = '0;
    exp_busy     = 1'b0;
    exp_mem_read = 1'b0;
    exp_achk     = 1'b1;
    exp_maddr    = '0;
    exp_miss     = '0;
    pend         = 1'b0;
    pend_fl      = 1'b0;
    chk_en       = 1'b1;
    tick();
    exp_achk = 1'b1;
    pin("rst_rdata", cpu_rdata, 32'h0);
    tick();
    exp_achk = 1'b1;
    reset_n  = 1'b1;
    tick();

    rd(32'h104, 64'h11112222_33334444, 0, -1, 0, 0, g);
    pin("cold_rdata", g, 32'h11112222);
    pin("cold_miss", 32'(miss_count), 32'd1);
    rd(32'h100, 64'h0, 0, -1, 0, 0, g);
    pin("hit_rdata", g, 32'h33334444);
    pin("hit_miss", 32'(miss_count), 32'd1);
    rd(32'h180, 64'hAAAA5555_BBBB6666, 0, -1, 0, 0, g);
    pin("conf_rdata", g, 32'hBBBB6666);
    rd(32'h100, 64'h11112222_33334444, 0, -1, 0, 0, g);
    pin("evict_miss", 32'(miss_count), 32'd3);
    rd(32'h200, 64'hCAFEF00D_DEADBEEF, 0, 100, 0, 0, g);
    pin("wflush_rdata", g, 32'hDEADBEEF);
    rd(32'h200, 64'h01010101_02020202, 0, -1, 0, 0, g);
    pin("wflush_miss", 32'(miss_count), 32'd5);
    rd(32'h200, 64'h0, 0, -1, 0, 0, g);
    pin("refill_hit", g, 32'h02020202);
    rd(32'h200, 64'h0BAD0BAD_05050505, 1, -1, 0, 0, g);
    pin("flreq_miss", 32'(miss_count), 32'd6);
    rd(32'h304, 64'h01234567_89ABCDEF, 0, -1, 1, 1, g);
    pin("stray_rdata", g, 32'h01234567);
    rd(32'h300, 64'h0, 0, -1, 0, 0, g);
    pin("b2b_lo", g, 32'h89ABCDEF);
    rd(32'h304, 64'h0, 0, -1, 0, 0, g);
    pin("b2b_hi", g, 32'h01234567);
    pin("b2b_miss", 32'(miss_count), 32'd7);
    rd_reset(32'h400);
    pin("rst_miss0", 32'(miss_count), 32'd0);
    rd(32'h104, 64'h77778888_9999AAAA, 0, -1, 0, 0, g);
    pin("rst_remiss", 32'(miss_count), 32'd1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 15) << 3)
          | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
        fa = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 200))
                                          : -1;
        rd(a, {$urandom, $urandom}, ($urandom_range(0, 9) == 0), fa,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), g);
      end else begin
        idle(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
      end
    end

    tick();
    tick();
    chk_en = 1'b0;
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
